// File: rtl/instr_encoder_if.sv
// Request/response bus of the instruction encoder: raw fields in, encoded words out.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    // Requester/consumer side
    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    // Encoder side
    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs raw fields into a 32-bit word, flags
// unencodable requests (stored as NOP), and buffers results in a 2-entry FIFO.
module instr_encoder (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_encoder_if.slave        bus,
    output logic [15:0]           enc_count
);
    localparam logic [31:0] Nop = 32'h0000_0013;

    // FIFO entry: {err, instr}
    logic [32:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic [32:0] enc_word;

    logic [31:0] imm;
    logic [6:0]  op;
    logic        imm12_ok;
    logic        imm13_ok;
    logic        imm21_ok;

    assign imm = bus.in_imm;
    assign op  = bus.in_opcode;

    // Sign-extension range checks: upper bits must all equal the field's sign bit
    assign imm12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign imm13_ok = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign imm21_ok = (imm[31:20] == '0) || (imm[31:20] == '1);

    // in_ready depends only on occupancy, so there is no path from out_ready
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.out_instr = bus.out_valid ? mem[rd_ptr][31:0] : 32'h0;
    assign bus.out_err   = bus.out_valid ? mem[rd_ptr][32] : 1'b0;

    // Format selection and immediate legality per opcode
    always_comb begin
        enc_instr = 32'h0;
        enc_err   = 1'b0;
        case (op)
            7'b0110011: begin
                enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, op};
            end
            7'b0000011, 7'b1100111: begin
                enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, op};
                enc_err   = !imm12_ok;
            end
            7'b0010011: begin
                if (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101) begin
                    enc_instr = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3,
                                 bus.in_rd, op};
                    enc_err   = (imm[31:5] != '0);
                end else begin
                    enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, op};
                    enc_err   = !imm12_ok;
                end
            end
            7'b0100011: begin
                enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], op};
                enc_err   = !imm12_ok;
            end
            7'b1100011: begin
                enc_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                             imm[4:1], imm[11], op};
                enc_err   = !imm13_ok || imm[0];
            end
            7'b1101111: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, op};
                enc_err   = !imm21_ok || imm[0];
            end
            7'b0110111, 7'b0010111: begin
                enc_instr = {imm[31:12], bus.in_rd, op};
                enc_err   = (imm[11:0] != '0);
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
        enc_word = enc_err ? {1'b1, Nop} : {1'b0, enc_instr};
    end

    // FIFO pointers and occupancy; push is gated by in_ready so a pop never frees a slot early
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_word;
    end

    // Saturating count of error-free words handed to the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= 16'h0;
        end else if (pop && !mem[rd_ptr][32] && enc_count != 16'hFFFF) begin
            enc_count <= enc_count + 16'h1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_instr_encoder;
    logic        clk;
    logic        rst_n;
    logic [15:0] enc_count;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .enc_count (enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [32:0] model_q[$];
    logic [15:0] exp_count = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: range checks on the signed value, fields placed by shift and mask
    function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] imm);
        longint      s = longint'($signed(imm));
        logic [31:0] w;
        bit          ok = 1'b1;
        logic [31:0] regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (op)
            7'h33: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
            7'h03, 7'h67: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7);
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    ok = (imm < 32);
                    w  = (32'(f7) << 25) | ((imm & 32'h1F) << 20) | regs | (32'(rd) << 7);
                end else begin
                    ok = (s >= -2048) && (s <= 2047);
                    w  = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7);
                end
            end
            7'h23: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
                     | ((imm & 32'h1F) << 7);
            end
            7'h63: begin
                ok = (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
                w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                     | (32'(rs2) << 20) | regs | (((imm >> 1) & 32'hF) << 8)
                     | (((imm >> 11) & 1) << 7);
            end
            7'h6F: begin
                ok = (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && (imm % 2 == 0);
                w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                     | (32'(rd) << 7) | 32'(op);
            end
            7'h37, 7'h17: begin
                ok = (imm % 4096 == 0);
                w  = imm | (32'(rd) << 7) | 32'(op);
            end
            default: begin
                ok = 1'b0;
                w  = 32'h0;
            end
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
    endfunction

    task automatic set_req(input logic v, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    task automatic check_outputs();
        logic [32:0] head = (model_q.size() > 0) ? model_q[0] : 33'h0;
        check("in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
        check("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
        check("out_instr", bus.out_instr, head[31:0]);
        check("out_err", 32'(bus.out_err), 32'(head[32]));
        check("enc_count", 32'(enc_count), 32'(exp_count));
    endtask

    // Check current outputs, advance one clock, then apply the handshakes to the model
    task automatic cycle();
        logic [32:0] word;
        bit          do_push;
        bit          do_pop;
        check_outputs();
        word    = model_enc(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3,
                            bus.in_funct7, bus.in_imm);
        do_push = bus.in_valid && (model_q.size() < 2);
        do_pop  = bus.out_ready && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop) begin
            if (!model_q[0][32] && exp_count != 16'hFFFF) exp_count++;
            void'(model_q.pop_front());
        end
        if (do_push) model_q.push_back(word);
    endtask

    task automatic rand_req();
        logic [6:0]  ops [12] = '{7'h33, 7'h03, 7'h67, 7'h13, 7'h13, 7'h23, 7'h63, 7'h6F,
                                  7'h37, 7'h17, 7'h7F, 7'h00};
        logic [31:0] imm;
        case ($urandom_range(0, 3))
            0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       imm = $urandom;
            2:       imm = $urandom & 32'hFFFF_F000;
            default: imm = 32'($urandom_range(0, 40));
        endcase
        set_req(1'($urandom_range(0, 1)), ops[$urandom_range(0, 11)], 5'($urandom),
                5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        set_req(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);

        // Reset values held while rst_n is low
        #3;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        #9;
        rst_n = 1'b1;

        // ADDI x1, x0, -1 accepted on the first edge after release
        set_req(1'b1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        cycle();
        check("addi_word", bus.out_instr, 32'hFFF0_0093);
        check("addi_err", 32'(bus.out_err), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycle();

        // BEQ then JAL
        bus.out_ready = 1'b0;
        set_req(1'b1, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        cycle();
        check("beq_word", bus.out_instr, 32'h0000_0463);
        set_req(1'b1, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        check("jal_word", bus.out_instr, 32'h0010_00EF);
        cycle();

        // Unencodable requests become NOP with out_err and do not count
        set_req(1'b1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        cycle();
        check("addi_big_word", bus.out_instr, 32'h0000_0013);
        check("addi_big_err", 32'(bus.out_err), 32'd1);
        set_req(1'b1, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        cycle();
        check("beq_odd_err", 32'(bus.out_err), 32'd1);
        bus.in_valid = 1'b0;
        cycle();
        check("err_count_held", 32'(enc_count), 32'd3);

        // Async reset with two words buffered
        bus.out_ready = 1'b0;
        set_req(1'b1, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'h0);
        cycle();
        cycle();
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_instr", bus.out_instr, 32'h0);
        check("arst_enc_count", 32'(enc_count), 32'd0);
        model_q.delete();
        exp_count = 16'h0;
        #2;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        cycle();

        // Backpressure: three offers against a stalled consumer
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_req(1'b1, 7'h13, 5'(i), 5'd2, 5'd0, 3'd0, 7'd0, 32'(i * 4));
            if (i < 3) cycle();
        end
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        check("bp_enc_count", 32'(enc_count), 32'd3);

        // Streaming with one word resident: push and pop every cycle
        bus.out_ready = 1'b0;
        set_req(1'b1, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        cycle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 7'h13, 5'($urandom), 5'($urandom), 5'd0, 3'd0, 7'd0,
                    32'($urandom_range(0, 2047)));
            cycle();
            check("stream_occupancy", 32'(bus.out_valid && bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_req();
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: request fields valid.
REQ-004 SHALL have port in_ready, output, 1 bit: encoder can accept a request; equals buffer-not-full.
REQ-005 SHALL have ports in_opcode (7), in_rd (5), in_rs1 (5), in_rs2 (5), in_funct3 (3), in_funct7 (7), all inputs: raw instruction fields.
REQ-006 SHALL have port in_imm, input, 32 bits: full-width signed immediate or offset; U-type takes the final upper value.
REQ-007 SHALL have port out_valid, output, 1 bit: buffer head holds an encoded word.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the head word.
REQ-009 SHALL have port out_instr, output, 32 bits: encoded instruction at buffer head.
REQ-010 SHALL have port out_err, output, 1 bit: head word came from an unencodable request.
REQ-011 SHALL have port enc_count, output, 16 bits: count of error-free words delivered.

Function
REQ-012 SHALL accept a request when in_valid and in_ready are both high at a clock edge; SHALL push the encoded word into a 2-entry FIFO on that edge.
REQ-013 SHALL present a word accepted at edge N on out_valid/out_instr after edge N; latency is 1 cycle when the FIFO is empty.
REQ-014 SHALL pop the head when out_valid and out_ready are both high; SHALL preserve word order.
REQ-015 SHALL derive in_ready only from FIFO occupancy, with no combinational path from out_ready; a push is refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-016 SHALL push and pop in the same cycle when the FIFO is non-full and non-empty; occupancy is then unchanged.
REQ-017 SHALL always encode bits [6:0] = in_opcode.
REQ-018 SHALL encode R (0110011) as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-019 SHALL encode I (0000011, 1100111, 0010011) as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-020 SHALL encode OP_IMM shifts (funct3 001/101) as {funct7, imm[4:0], rs1, funct3, rd, opcode}.
REQ-021 SHALL encode S (0100011) as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-022 SHALL encode B (1100011) as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-023 SHALL encode J (1101111) as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-024 SHALL encode U (0110111, 0010111) as {imm[31:12], rd, opcode}.
REQ-025 SHALL flag an error on any of these conditions:
- I/S: imm[31:11] not all equal.
- Shift: imm[31:5] nonzero.
- B: imm[31:12] not all equal, or imm[0]=1.
- J: imm[31:20] not all equal, or imm[0]=1.
- U: imm[11:0] nonzero.
- Any opcode not listed above.
REQ-026 SHALL, on error, store out_instr = 0x00000013 (NOP) with out_err = 1 in the FIFO; the word still occupies a slot and obeys the handshake.
REQ-027 SHALL increment enc_count on each pop with out_err = 0; SHALL saturate enc_count at 0xFFFF.
REQ-028 SHALL drive out_instr = 0 and out_err = 0 whenever out_valid = 0.

Reset
REQ-029 SHALL, while rst_n = 0, immediately force FIFO empty, out_valid = 0, out_instr = 0, out_err = 0, enc_count = 0, in_ready = 1.
REQ-030 SHALL discard any buffered words when reset asserts mid-operation; no word is delivered after reset release until a new push.
REQ-031 SHALL accept a request on the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL cover ADDI: opcode 0x13, rd = 1, rs1 = 0, f3 = 0, imm = 0xFFFFFFFF -> next cycle out_instr = 0xFFF00093, out_err = 0.
REQ-033 SHALL cover BEQ: opcode 0x63, rs1 = rs2 = 0, f3 = 0, imm = 8 -> out_instr = 0x00000463; then JAL with rd = 1, imm = 0x800 -> out_instr = 0x001000EF.
REQ-034 SHALL cover errors:
- ADDI with imm = 2048 -> out_instr = 0x00000013, out_err = 1.
- BEQ with imm = 3 -> out_err = 1.
- enc_count unchanged after popping both.
REQ-035 SHALL cover backpressure: out_ready = 0, offer 3 requests -> in_ready low after 2 accepts; raise out_ready -> words emerge in order, then the third is accepted; enc_count = 3.
REQ-036 SHALL cover async reset: FIFO holding 2 words, rst_n pulsed low between clock edges -> out_valid = 0 and in_ready = 1 without waiting for a clock edge; enc_count = 0.
REQ-037 SHALL cover simultaneous push/pop with 1 word held for 4 cycles -> one word delivered per cycle, occupancy stays 1.
